// File: rtl/periph_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : periph_tx_sequencer_if
//  Purpose  : Bundles the arbiter, peripheral-FIFO and downstream transmit
//             signals used by periph_tx_sequencer.
//             master : the sequencer side (pops FIFOs, drives tx words)
//             slave  : the environment side (arbiter, FIFOs, FT601 sink)
//  Signals  : grant[2:0]          arbiter's currently granted peripheral
//             rx_fifo_empty[7:0]  per-peripheral FWFT empty flags
//             rx_fifo_dout        8 x DATA_W flattened FIFO heads
//             rx_fifo_rd[7:0]     one-hot pop strobes
//             tx_ready            downstream accepts a word
//             tx_valid/tx_data/tx_last  transmit word, trailer marker
//             read_periph_data    pulse telling the arbiter to move on
//             busy                sequencer not idle
//             timeout_err         stall-abort pulse
//  Revision : 1.0  initial release
// ============================================================================
interface periph_tx_sequencer_if #(
    parameter int DATA_W = 32
);
    logic [2:0]          grant;
    logic [7:0]          rx_fifo_empty;
    logic [8*DATA_W-1:0] rx_fifo_dout;
    logic [7:0]          rx_fifo_rd;
    logic                tx_ready;
    logic                tx_valid;
    logic [DATA_W-1:0]   tx_data;
    logic                tx_last;
    logic                read_periph_data;
    logic                busy;
    logic                timeout_err;

    modport master (
        input  grant, rx_fifo_empty, rx_fifo_dout, tx_ready,
        output rx_fifo_rd, tx_valid, tx_data, tx_last,
               read_periph_data, busy, timeout_err
    );

    modport slave (
        output grant, rx_fifo_empty, rx_fifo_dout, tx_ready,
        input  rx_fifo_rd, tx_valid, tx_data, tx_last,
               read_periph_data, busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/periph_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : periph_tx_sequencer
//  Purpose  : Drains the granted peripheral FIFO into the downstream write
//             path as packets: header word, 1..MAX_BURST data words, trailer
//             word carrying the data count, then a one-cycle pulse to the
//             arbiter so it can advance the grant.
//  Ports    : clk    - single clock, rising edge
//             rst_n  - asynchronous active-low reset
//             bus    - periph_tx_sequencer_if.master (see interface header)
//  Params   : DATA_W (>=32), MAX_BURST (1..255), TIMEOUT (1..65535)
//  Options  : STALL_TIMEOUT_EN - when defined, a packet stalled for TIMEOUT
//             consecutive cycles is aborted with a timeout_err pulse and
//             released without a trailer. Undefined: stalls wait forever.
//  Revision : 1.0  initial release
// ============================================================================
module periph_tx_sequencer #(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    periph_tx_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_BURST   = 3'd2,
        S_TRAILER = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam logic [7:0] c_max_burst = 8'(MAX_BURST);
    localparam logic [7:0] c_hdr_tag   = 8'hA5;
    localparam logic [7:0] c_trl_tag   = 8'h5A;

    // Out-of-range parameters are rejected at elaboration.
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("periph_tx_sequencer: MAX_BURST must be 1..255");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("periph_tx_sequencer: TIMEOUT must be 1..65535");
    end
    if (DATA_W < 32) begin : g_bad_data_w
        $error("periph_tx_sequencer: DATA_W must be at least 32");
    end

    state_t            state_q, state_d;
    logic [2:0]        cur_id_q, cur_id_d;
    logic [7:0]        count_q, count_d;
    // Set on the first edge after reset release; IDLE may only leave once
    // armed, so the first state change lands on the second edge.
    logic              armed_q;

    logic              w_cur_empty;
    logic              w_valid_raw;
    logic              w_xfer;
    logic              w_timeout;
    logic [DATA_W-1:0] w_tx_data;
    logic              w_tx_last;
    logic [7:0]        w_rd;
    logic              w_release;

    assign w_cur_empty = bus.rx_fifo_empty[cur_id_q];

    // Word offered before any stall-abort masking.
    assign w_valid_raw = (state_q == S_HEADER) || (state_q == S_TRAILER) ||
                         ((state_q == S_BURST) && !w_cur_empty);
    assign w_xfer      = w_valid_raw && bus.tx_ready;

`ifdef STALL_TIMEOUT_EN
    logic [15:0] stall_q, stall_d;
    logic        w_stall;

    assign w_stall   = w_valid_raw && !bus.tx_ready;
    // Abort on the TIMEOUT-th consecutive stalled cycle.
    assign w_timeout = w_stall && (stall_q == 16'(TIMEOUT - 1));

    always_comb begin
        stall_d = '0;
        if (w_stall && !w_timeout) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cur_id_q <= '0;
            count_q  <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            count_q  <= count_d;
            armed_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_id_d  = cur_id_q;
        count_d   = count_q;
        w_tx_data = '0;
        w_tx_last = 1'b0;
        w_rd      = '0;
        w_release = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (armed_q && !bus.rx_fifo_empty[bus.grant]) begin
                    cur_id_d = bus.grant;
                    count_d  = '0;
                    state_d  = S_HEADER;
                end
            end

            S_HEADER: begin
                w_tx_data = DATA_W'({c_hdr_tag, 16'h0000, 5'b00000, cur_id_q});
                if (w_xfer) begin
                    state_d = S_BURST;
                end
            end

            S_BURST: begin
                w_tx_data      = bus.rx_fifo_dout[int'(cur_id_q)*DATA_W +: DATA_W];
                w_rd[cur_id_q] = w_xfer;
                if (w_xfer) begin
                    count_d = count_q + 8'd1;
                    if (count_q + 8'd1 == c_max_burst) begin
                        state_d = S_TRAILER;
                    end
                end else if (w_cur_empty && (count_q != 8'd0)) begin
                    // FIFO ran dry after at least one word: close the packet.
                    state_d = S_TRAILER;
                end
            end

            S_TRAILER: begin
                w_tx_last = 1'b1;
                w_tx_data = DATA_W'({c_trl_tag, 5'b00000, cur_id_q, 8'h00, count_q});
                if (w_xfer) begin
                    state_d = S_RELEASE;
                end
            end

            S_RELEASE: begin
                w_release = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A stall abort skips the trailer and hands the grant back.
        if (w_timeout) begin
            w_rd    = '0;
            state_d = S_RELEASE;
        end
    end

    assign bus.tx_valid         = w_valid_raw && !w_timeout;
    assign bus.tx_data          = w_tx_data;
    assign bus.tx_last          = w_tx_last;
    assign bus.rx_fifo_rd       = w_rd;
    assign bus.read_periph_data = w_release;
    assign bus.busy             = (state_q != S_IDLE);
    assign bus.timeout_err      = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_periph_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_periph_tx_sequencer
//  Purpose  : Self-checking bench for periph_tx_sequencer. FIFOs are modelled
//             as arrays with read/write pointers; the expected word stream is
//             built from the packet rules (header, chunks of at most
//             MAX_BURST words, trailer with count) and compared against every
//             transferred word. Honours STALL_TIMEOUT_EN when defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_periph_tx_sequencer;

    localparam int DW = 32;
    localparam int MB = 16;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    periph_tx_sequencer_if #(.DATA_W(DW)) bus();

    periph_tx_sequencer #(
        .DATA_W   (DW),
        .MAX_BURST(MB),
        .TIMEOUT  (TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [DW-1:0] mem [8][64];
    int            rp [8];
    int            wp [8];
    logic [DW:0]   exp_q [$];
    logic [DW:0]   got_q [$];

    int passes = 0;
    int total  = 0;
    int fails  = 0;

    int            mode;
    int            pos;
    logic [2:0]    cur_tb;
    logic          prev_stall;
    logic [DW-1:0] prev_d;
    logic          chk_hold;
    int            cyc;
    int            rpd_cnt;
    int            te_cnt;
    int            te_idx;
    int            rpd_idx;
    int            first_valid;
    int            exp_pkts;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 8; i++) begin
            bus.rx_fifo_empty[i]           = (rp[i] == wp[i]);
            bus.rx_fifo_dout[i*DW +: DW]   = mem[i][rp[i]];
        end
        case (mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = ~bus.tx_ready;
            2:       bus.tx_ready = 1'($urandom_range(0, 1));
            default: bus.tx_ready = 1'b0;
        endcase
    endtask

    // One clock: observe at negedge, apply pops after posedge, then refresh.
    task automatic cycle();
        logic          v, r, l;
        logic [DW-1:0] d;
        logic [7:0]    rd, exp_rd;
        @(negedge clk);
        cyc++;
        v  = bus.tx_valid;
        r  = bus.tx_ready;
        l  = bus.tx_last;
        d  = bus.tx_data;
        rd = bus.rx_fifo_rd;
        exp_rd = 8'h00;
        if (v && r && pos > 0 && !l) exp_rd[cur_tb] = 1'b1;
        check("pop_strobe", 64'(rd), 64'(exp_rd));
        if (chk_hold && prev_stall) begin
            check("hold_valid", 64'(v), 64'd1);
            check("hold_data", 64'(d), 64'(prev_d));
        end
        if (v && r) begin
            got_q.push_back({l, d});
            if (pos == 0) cur_tb = d[2:0];
            pos = l ? 0 : pos + 1;
        end
        prev_stall = v && !r;
        prev_d     = d;
        if (bus.read_periph_data) begin
            rpd_cnt++;
            rpd_idx = cyc;
        end
        if (bus.timeout_err) begin
            te_cnt++;
            te_idx = cyc;
        end
        if (v && first_valid < 0) first_valid = cyc;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            if (rd[i] && rp[i] != wp[i]) rp[i]++;
        end
        #1;
        drive_inputs();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic fresh(input int m);
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            rp[i] = 0;
            wp[i] = 0;
        end
        pos          = 0;
        prev_stall   = 1'b0;
        rpd_cnt      = 0;
        te_cnt       = 0;
        te_idx       = -1;
        rpd_idx      = -1;
        first_valid  = -1;
        exp_pkts     = 0;
        chk_hold     = 1'b1;
        mode         = m;
        bus.tx_ready = 1'b0;
    endtask

    task automatic load(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            mem[id][wp[id]] = $urandom;
            wp[id]++;
        end
    endtask

    // Expected stream for n words of FIFO id starting at entry 'first'.
    task automatic expect_pkts(input int id, input int first, input int n);
        int idx;
        int left;
        int k;
        idx  = first;
        left = n;
        while (left > 0) begin
            k = (left > MB) ? MB : left;
            exp_q.push_back({1'b0, 32'hA500_0000 | 32'(id)});
            for (int j = 0; j < k; j++) begin
                exp_q.push_back({1'b0, mem[id][idx]});
                idx++;
            end
            exp_q.push_back({1'b1, 32'h5A00_0000 | (32'(id) << 16) | 32'(k)});
            exp_pkts++;
            left -= k;
        end
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
        end
        check({tag, "_rpd"}, 64'(rpd_cnt), 64'(exp_pkts));
        check({tag, "_terr"}, 64'(te_cnt), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 64'(bus.tx_valid), 64'd0);
        check({tag, "_data"},  64'(bus.tx_data), 64'd0);
        check({tag, "_last"},  64'(bus.tx_last), 64'd0);
        check({tag, "_rd"},    64'(bus.rx_fifo_rd), 64'd0);
        check({tag, "_rpd"},   64'(bus.read_periph_data), 64'd0);
        check({tag, "_busy"},  64'(bus.busy), 64'd0);
        check({tag, "_terr"},  64'(bus.timeout_err), 64'd0);
    endtask

    initial begin
        int id;
        int n;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 64; j++) mem[i][j] = '0;
        end
        bus.grant = 3'd0;
        fresh(0);
        drive_inputs();

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");

        // Basic packet from FIFO3, plus reset-release latency
        fresh(0);
        load(3, 5);
        expect_pkts(3, 0, 5);
        bus.grant = 3'd3;
        drive_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arm_edge1_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        check("arm_edge2_busy", 64'(bus.busy), 64'd1);
        check("hdr_word", 64'(bus.tx_data), 64'hA500_0003);
        run(30);
        compare_stream("basic");

        // 20 words with MAX_BURST 16: two packets of 16 and 4
        fresh(0);
        load(0, 20);
        expect_pkts(0, 0, 20);
        bus.grant = 3'd0;
        drive_inputs();
        run(60);
        compare_stream("maxburst");

        // tx_ready toggling every cycle
        fresh(1);
        load(1, 7);
        expect_pkts(1, 0, 7);
        bus.grant = 3'd1;
        drive_inputs();
        run(60);
        compare_stream("toggle");

        // Grant moves from 2 to 5 in the middle of the burst
        fresh(0);
        load(2, 10);
        load(5, 3);
        expect_pkts(2, 0, 10);
        expect_pkts(5, 0, 3);
        bus.grant = 3'd2;
        drive_inputs();
        run(5);
        bus.grant = 3'd5;
        run(60);
        compare_stream("regrant");

        // Random peripheral, length and backpressure
        for (int it = 0; it < 3; it++) begin
            fresh(2);
            id = $urandom_range(0, 7);
            n  = $urandom_range(1, 40);
            load(id, n);
            expect_pkts(id, 0, n);
            bus.grant = 3'(id);
            drive_inputs();
            run(250);
            compare_stream("random");
        end

        // Reset in BURST after 3 data words
        fresh(0);
        load(4, 8);
        bus.grant = 3'd4;
        drive_inputs();
        for (int k = 0; k < 40 && got_q.size() < 4; k++) cycle();
        check("mid_rst_words_before", 64'(got_q.size()), 64'd4);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        pos        = 0;
        prev_stall = 1'b0;
        exp_q.push_back({1'b0, 32'hA500_0004});
        for (int j = 0; j < 3; j++) exp_q.push_back({1'b0, mem[4][j]});
        expect_pkts(4, 3, 5);
        run(40);
        compare_stream("mid_rst");

`ifdef STALL_TIMEOUT_EN
        // Stall abort in HEADER
        fresh(3);
        chk_hold = 1'b0;
        load(6, 2);
        bus.grant = 3'd6;
        drive_inputs();
        for (int k = 0; k < 40 && rpd_cnt == 0; k++) cycle();
        check("to_terr_count", 64'(te_cnt), 64'd1);
        check("to_terr_cycle", 64'(te_idx - first_valid), 64'd7);
        check("to_rpd_cycle", 64'(rpd_idx - te_idx), 64'd1);
        check("to_no_pop", 64'(rp[6]), 64'd0);
        check("to_no_words", 64'(got_q.size()), 64'd0);
        mode         = 0;
        bus.tx_ready = 1'b1;
        rpd_cnt      = 0;
        te_cnt       = 0;
        pos          = 0;
        expect_pkts(6, 0, 2);
        run(30);
        compare_stream("after_to");
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/periph_tx_sequencer.md
PERIPH_TX_SEQUENCER -- requirements
Module: periph_tx_sequencer

Interface
REQ-001 Parameter DATA_W, default 32, width of peripheral FIFO words and of tx_data.
REQ-002 Parameter MAX_BURST, default 16, maximum data words per packet; legal range 1..255.
REQ-003 Parameter TIMEOUT, default 255, stall-cycle limit used only when STALL_TIMEOUT_EN is defined; legal range 1..65535.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 grant  in  3  peripheral index currently granted by the arbiter.
REQ-007 rx_fifo_empty  in  8  per-peripheral FIFO empty flags, first-word-fall-through.
REQ-008 rx_fifo_dout  in  8*DATA_W  flattened FIFO outputs; peripheral i occupies bits [i*DATA_W +: DATA_W].
REQ-009 rx_fifo_rd  out  8  one-hot pop strobes, at most one bit high per cycle.
REQ-010 tx_ready  in  1  downstream (FT601 write path) accepts a word this cycle.
REQ-011 tx_valid  out  1  tx_data holds a word.
REQ-012 tx_data  out  DATA_W  header, data or trailer word.
REQ-013 tx_last  out  1  marks the trailer word.
REQ-014 read_periph_data  out  1  one-cycle pulse to the arbiter to advance its grant.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 timeout_err  out  1  one-cycle pulse on stall abort.

Function
REQ-017 Transfer occurs on a cycle with tx_valid=1 and tx_ready=1; tx_valid and tx_data hold stable until transfer.
REQ-018 States are IDLE, HEADER, BURST, TRAILER, RELEASE.
REQ-019 IDLE: if rx_fifo_empty[grant]=0, latch grant into cur_id, clear count, and go to HEADER; otherwise stay.
REQ-020 HEADER: tx_valid=1; tx_data={8'hA5, 16'h0000, 5'b0, cur_id}, zero-extended to DATA_W; go to BURST on transfer.
REQ-021 BURST: tx_valid = ~rx_fifo_empty[cur_id]; tx_data = dout[cur_id]; rx_fifo_rd[cur_id] = tx_valid & tx_ready; count increments on each transfer.
REQ-022 BURST exit: go to TRAILER on the transfer that makes count=MAX_BURST, or on any cycle where rx_fifo_empty[cur_id]=1 and count>=1.
REQ-023 TRAILER: tx_valid=1, tx_last=1, tx_data={8'h5A, 5'b0, cur_id, 8'h00, count[7:0]}; go to RELEASE on transfer.
REQ-024 RELEASE: read_periph_data=1 for exactly one cycle, then go to IDLE; grant is not sampled until the following cycle.
REQ-025 grant changes during HEADER through RELEASE are ignored; only cur_id selects the FIFO.
REQ-026 Packet length is always count+2 words, with 1 <= count <= MAX_BURST.
REQ-027 tx_last, rx_fifo_rd and read_periph_data are 0 in all states not named above.
REQ-028 If count reaches MAX_BURST while the FIFO is still non-empty, the packet ends anyway; the remaining data is sent in a later packet after re-arbitration.

Reset
REQ-029 Assertion of rst_n=0 immediately forces the state to IDLE and drives all outputs to 0: tx_valid, tx_data, tx_last, rx_fifo_rd, read_periph_data, busy and timeout_err; count=0 and cur_id=0.
REQ-030 Reset mid-packet abandons the packet with no trailer and no read_periph_data pulse.
REQ-031 After rst_n deasserts, the first state transition occurs on the second rising edge of clk.

Configuration
REQ-032 Macro STALL_TIMEOUT_EN defined: a 16-bit counter counts consecutive cycles with tx_valid=1 and tx_ready=0 in HEADER, BURST or TRAILER, and clears on any transfer.
REQ-033 With STALL_TIMEOUT_EN defined, reaching TIMEOUT causes a one-cycle timeout_err pulse, drops tx_valid, issues no pop, and goes to RELEASE without sending a trailer.
REQ-034 Macro STALL_TIMEOUT_EN undefined: no stall counter exists, timeout_err is constant 0, and stalls wait indefinitely.

Verification
REQ-035 grant=3, FIFO3 holds 5 words, tx_ready=1 -> header A5000003, 5 data words in order, trailer 5A030005 with tx_last, then a single read_periph_data pulse.
REQ-036 MAX_BURST=16, FIFO0 holds 20 words -> first packet has 16 data words and trailer count 0x10; after re-grant, second packet has 4 data words.
REQ-037 tx_ready toggling 1/0 each cycle during BURST -> no duplicated or dropped words, rx_fifo_rd only on transfer cycles, tx_data stable while stalled.
REQ-038 grant changes from 2 to 5 mid-BURST -> all pops stay on FIFO2, and the trailer id is 2.
REQ-039 rst_n pulsed low in BURST after 3 words -> outputs 0 in the same cycle, no trailer, and IDLE resumes afterwards.
REQ-040 With STALL_TIMEOUT_EN and TIMEOUT=8, tx_ready held 0 in HEADER -> timeout_err pulses on the 8th stall cycle, no pops occur, and read_periph_data pulses on the next cycle.
